// File: rtl/iterative_bit_counter_if.sv
// iterative_bit_counter_if: operand/result handshake bundle for the iterative bit counter
interface iterative_bit_counter_if #(parameter int WIDTH = 8);
  localparam int QW = $clog2(WIDTH + 1);
  logic load;
  logic [1:0] mode;
  logic [WIDTH-1:0] a;
  logic [QW-1:0] q;
  logic busy;
  logic done;
  modport master(output load, mode, a, input q, busy, done);
  modport slave(input load, mode, a, output q, busy, done);
endinterface

// File: rtl/iterative_bit_counter.sv
// iterative_bit_counter: multi-cycle popcount / tz / lz / parity over STEP bits per clock
module iterative_bit_counter #(
  parameter int WIDTH = 8,
  parameter int STEP = 1
) (
  input logic clk,
  input logic rst,
  iterative_bit_counter_if.slave bus
);
  localparam int QW = $clog2(WIDTH + 1);
  localparam int N = WIDTH / STEP;
  localparam int BW = N > 1 ? $clog2(N) : 1;
  if (WIDTH < 2 || WIDTH % STEP != 0) begin : g_bad_params
    $error("iterative_bit_counter: WIDTH must be >= 2 and a multiple of STEP");
  end
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] sr, rev;
  logic [QW-1:0] acc, acc_n, q;
  logic [BW-1:0] beat;
  logic [1:0] md;
  logic seen, seen_n, done, last;
  assign last = state == BUSY && beat == BW'(N - 1);
  assign bus.busy = state == BUSY;
  assign bus.q = q;
  assign bus.done = done;
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // next state: leave IDLE on load, return on the final beat
  always_comb begin
    state_n = state;
    if (state == IDLE && bus.load) state_n = BUSY;
    else if (last) state_n = IDLE;
  end
  // leading-zero count reuses the trailing-zero path on the reversed operand
  always_comb begin
    rev = '0;
    for (int i = 0; i < WIDTH; i++) rev[i] = bus.a[WIDTH-1-i];
  end
  // fold the low STEP bits of the shift register into the accumulator, LSB first
  always_comb begin
    acc_n = acc;
    seen_n = seen;
    for (int i = 0; i < STEP; i++) begin
      if (md == 2'b00) acc_n = acc_n + QW'(sr[i]);
      else if (md == 2'b11) acc_n[0] = acc_n[0] ^ sr[i];
      else if (!seen_n) begin
        if (sr[i]) seen_n = 1'b1;
        else acc_n = acc_n + QW'(1);
      end
    end
  end
  // datapath: capture on load, shift/accumulate while busy, publish on the last beat
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
      done <= 1'b0;
      beat <= '0;
      acc <= '0;
      seen <= 1'b0;
      sr <= '0;
      md <= 2'b00;
    end else begin
      done <= last;
      if (state == IDLE && bus.load) begin
        md <= bus.mode;
        sr <= bus.mode == 2'b10 ? rev : bus.a;
        acc <= '0;
        seen <= 1'b0;
        beat <= '0;
      end else if (state == BUSY) begin
        sr <= sr >> STEP;
        acc <= acc_n;
        seen <= seen_n;
        beat <= beat + BW'(1);
        if (last) q <= acc_n;
      end
    end
  end
endmodule

// File: tb/tb_iterative_bit_counter.sv
// tb_iterative_bit_counter: directed checks on three configurations of the iterative bit counter
module tb_iterative_bit_counter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] ld = '0;
  logic [1:0] mode = 2'b00;
  logic [15:0] a = '0;
  int checks = 0;
  int errors = 0;
  logic [7:0] hist [0:63];
  always #5 clk = ~clk;
  iterative_bit_counter_if #(.WIDTH(8)) b81();
  iterative_bit_counter_if #(.WIDTH(8)) b84();
  iterative_bit_counter_if #(.WIDTH(16)) b16();
  assign b81.load = ld[0];
  assign b84.load = ld[1];
  assign b16.load = ld[2];
  assign b81.mode = mode;
  assign b84.mode = mode;
  assign b16.mode = mode;
  assign b81.a = a[7:0];
  assign b84.a = a[7:0];
  assign b16.a = a;
  iterative_bit_counter #(.WIDTH(8), .STEP(1)) u81(.clk(clk), .rst(rst), .bus(b81.slave));
  iterative_bit_counter #(.WIDTH(8), .STEP(4)) u84(.clk(clk), .rst(rst), .bus(b84.slave));
  iterative_bit_counter #(.WIDTH(16), .STEP(2)) u16(.clk(clk), .rst(rst), .bus(b16.slave));
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  function automatic int get_q(input int s);
    return s == 0 ? int'(b81.q) : s == 1 ? int'(b84.q) : int'(b16.q);
  endfunction
  function automatic logic get_busy(input int s);
    return s == 0 ? b81.busy : s == 1 ? b84.busy : b16.busy;
  endfunction
  function automatic logic get_done(input int s);
    return s == 0 ? b81.done : s == 1 ? b84.done : b16.done;
  endfunction
  task automatic op(input int s, input logic [15:0] v, input logic [1:0] m, input int n, input int exp, input string tag);
    int cnt, busy_cnt, q_moved, q_prev;
    q_prev = get_q(s);
    @(negedge clk);
    a = v;
    mode = m;
    ld[s] = 1'b1;
    @(posedge clk);
    #1;
    ld[s] = 1'b0;
    a = ~v;
    mode = ~m;
    cnt = 0;
    busy_cnt = 0;
    q_moved = 0;
    while (!get_done(s) && cnt < 40) begin
      if (get_busy(s)) busy_cnt++;
      if (get_q(s) != q_prev) q_moved++;
      @(posedge clk);
      #1;
      cnt++;
    end
    check({tag, "_lat"}, cnt, n);
    check({tag, "_busy"}, busy_cnt, n);
    check({tag, "_hold"}, q_moved, 0);
    check({tag, "_q"}, get_q(s), exp);
    check({tag, "_busy_end"}, int'(get_busy(s)), 0);
    @(posedge clk);
    #1;
    check({tag, "_done_drop"}, int'(get_done(s)), 0);
  endtask
  initial begin
    ld[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      check("rst_q", get_q(s), 0);
      check("rst_busy", int'(get_busy(s)), 0);
      check("rst_done", int'(get_done(s)), 0);
    end
    ld[0] = 1'b0;
    rst = 1'b0;
    op(0, 16'h00FF, 2'b00, 8, 8, "pop_ff");
    op(0, 16'h0010, 2'b01, 8, 4, "tz_10");
    op(0, 16'h0010, 2'b10, 8, 3, "lz_10");
    op(0, 16'h0010, 2'b11, 8, 1, "par_10");
    op(0, 16'h0000, 2'b01, 8, 8, "tz_00");
    op(0, 16'h0000, 2'b10, 8, 8, "lz_00");
    op(0, 16'h0000, 2'b00, 8, 0, "pop_00");
    op(0, 16'h0000, 2'b11, 8, 0, "par_00");
    op(0, 16'h00FF, 2'b01, 8, 0, "tz_ff");
    op(0, 16'h00FF, 2'b10, 8, 0, "lz_ff");
    op(0, 16'h00FF, 2'b11, 8, 0, "par_ff");
    op(0, 16'h00A0, 2'b10, 8, 0, "lz_a0");
    op(0, 16'h00A0, 2'b11, 8, 0, "par_a0");
    op(1, 16'h00B6, 2'b00, 2, 5, "s4_pop");
    op(1, 16'h00B6, 2'b11, 2, 1, "s4_par");
    op(1, 16'h0010, 2'b01, 2, 4, "s4_tz");
    op(1, 16'h0000, 2'b10, 2, 8, "s4_lz0");
    op(2, 16'h8000, 2'b10, 8, 0, "w16_lz");
    op(2, 16'h8000, 2'b01, 8, 15, "w16_tz");
    op(2, 16'h0000, 2'b01, 8, 16, "w16_tz0");
    op(2, 16'hFFFF, 2'b00, 8, 16, "w16_pop");
    op(2, 16'h0600, 2'b10, 8, 5, "w16_lz6");
    @(negedge clk);
    mode = 2'b00;
    ld[0] = 1'b1;
    for (int c = 0; c < 45; c++) begin
      a = 16'($urandom);
      hist[c] = a[7:0];
      @(posedge clk);
      #1;
      if (c % 9 == 8) begin
        check("cont_done", int'(b81.done), 1);
        check("cont_q", int'(b81.q), $countones(hist[c-8]));
      end else check("cont_nodone", int'(b81.done), 0);
    end
    ld[0] = 1'b0;
    @(posedge clk);
    #1;
    check("cont_idle", int'(b81.busy), 0);
    @(negedge clk);
    a = 16'h00FF;
    mode = 2'b00;
    ld[0] = 1'b1;
    @(posedge clk);
    #1;
    ld[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy", int'(b81.busy), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_q", int'(b81.q), 0);
    check("mid_rst_busy", int'(b81.busy), 0);
    check("mid_rst_done", int'(b81.done), 0);
    repeat (8) @(posedge clk);
    #1;
    check("mid_no_done", int'(b81.done), 0);
    check("mid_q_kept", int'(b81.q), 0);
    op(0, 16'h000F, 2'b00, 8, 4, "after_rst");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
